controle_movimento: RTL
=======================

CONTROLE_MOVIMENTO -- requirements
Module: controle_movimento

Interface
REQ-001 Parameter T_PARADO, default 2: PARADO duration, in ticks.
REQ-002 Parameter T_GIRO, default 3: GIRO duration, in ticks.
REQ-003 Parameter T_RE, default 2: RE duration, in ticks.
REQ-004 Port clk, input, 1: the single clock; all state SHALL change on its rising edge.
REQ-005 Port reset, input, 1: asynchronous, active-high reset.
REQ-006 Port power, input, 1: toy power switch; 1 = on.
REQ-007 Port tick, input, 1: one-cycle timing strobe from the frequency divider.
REQ-008 Port pulso_velocidade, input, 1: one-cycle, debounced speed-button pulse.
REQ-009 Port motor_esq, output, 2: left motor code; 01 = forward, 10 = reverse, 00 = stop.
REQ-010 Port motor_dir, output, 2: right motor code; same encoding as motor_esq.
REQ-011 Port estado, output, 3: current FSM state code, for the display.
REQ-012 Port velocidade, output, 2: current speed level, 0 to 3.
REQ-013 Port contagem_acao, output, 4: completed-cycle count as a BCD digit, 0 to 9.

Function
REQ-014 The FSM SHALL have states DESLIGADO, PARADO, FRENTE, GIRO and RE.
REQ-015 Motor outputs SHALL be decoded from the state register and SHALL be valid in the same cycle as the state: FRENTE 01/01; GIRO 01/10 (esq/dir); RE 10/10; DESLIGADO and PARADO 00/00.
REQ-016 If power=0, the next edge SHALL force DESLIGADO, velocidade=1, contagem_acao=0 and timer=0, overriding every other input.
REQ-017 In DESLIGADO with power=1, the next edge SHALL enter PARADO without waiting for a tick.
REQ-018 Every state entry SHALL load the timer with (duration-1), so a state with duration N SHALL last exactly N tick pulses.
REQ-019 On a tick with timer>0, the timer SHALL decrement.
REQ-020 On a tick with timer=0, the FSM SHALL transition as follows: PARADO->FRENTE, FRENTE->GIRO, GIRO->RE, RE->FRENTE.
REQ-021 The FRENTE duration SHALL be taken from velocidade at FRENTE entry: 1->12 ticks, 2->8 ticks, 3->4 ticks.
REQ-022 A pulso_velocidade pulse SHALL advance velocidade 1->2->3->0->1 at the next edge; the pulse SHALL be ignored in DESLIGADO.
REQ-023 If velocidade=0 in any active state, the next edge SHALL enter PARADO with the timer reloaded to T_PARADO-1.
REQ-024 While velocidade=0, PARADO SHALL hold, with the timer frozen and ticks ignored.
REQ-025 A speed change to a nonzero value SHALL NOT alter the duration of an in-progress FRENTE; it SHALL apply from the next FRENTE entry.
REQ-026 When tick and pulso_velocidade occur in the same cycle, both SHALL take effect at that edge: the tick uses the old speed, velocidade updates.
REQ-027 If that same-cycle event makes velocidade 0, the PARADO entry of REQ-023 SHALL take priority over any tick-driven transition.
REQ-028 contagem_acao SHALL increment on each RE->FRENTE transition and SHALL wrap 9->0.
REQ-029 contagem_acao SHALL NOT change on FSM transitions other than RE->FRENTE.
REQ-030 contagem_acao SHALL hold while the FSM is paused in PARADO.
REQ-031 tick SHALL be ignored in DESLIGADO.
REQ-032 A tick and a state entry in the same cycle SHALL load the timer without decrementing it.

Reset
REQ-033 Asserting reset SHALL immediately, without a clock, set: state DESLIGADO, motor_esq=00, motor_dir=00, velocidade=1, contagem_acao=0, timer=0.
REQ-034 Reset asserted mid-operation SHALL abort the current action with no partial count update.
REQ-035 After reset deasserts with power=1, the first edge SHALL enter PARADO.

Structure
REQ-036 A shared package SHALL hold the state encoding: DESLIGADO=000, PARADO=001, FRENTE=010, GIRO=011, RE=100.
REQ-037 The same package SHALL hold the motor codes and the FRENTE duration table (12, 8, 4).
REQ-038 The down-counter SHALL be a separate sub-module, temporizador_acao, with ports load, load_value, enable and zero, 4 bits wide.
REQ-039 The FSM, the speed register and the BCD counter SHALL reside in controle_movimento.

Verification
REQ-040 The bench SHALL cover power-up: reset, then power=1, then 2 ticks. Required: PARADO after 1 edge; FRENTE after the 2nd tick; motors 01/01.
REQ-041 The bench SHALL cover a full cycle at velocidade=1: 12+3+2 ticks spent in FRENTE, GIRO and RE in turn. Required: return to FRENTE and contagem_acao=1.
REQ-042 The bench SHALL cover the speed button: 3 pulses during FRENTE. Required: velocidade 2, 3, then 0; PARADO on the next edge; motors 00/00; ticks ignored.
REQ-043 The bench SHALL cover BCD wrap: 10 complete cycles. Required: contagem_acao counts 1..9, then 0.
REQ-044 The bench SHALL cover power drop and reset mid-GIRO. Required: power=0 gives DESLIGADO at the next edge with counters cleared; reset gives DESLIGADO asynchronously with no clock.
REQ-045 The bench SHALL cover simultaneous events: tick and pulso_velocidade in the same cycle at timer=0 in FRENTE with velocidade=2. Required: GIRO entered, velocidade=3, next FRENTE lasts 4 ticks.

Source files
------------

// File: rtl/controle_movimento_pkg.sv
// Shared definitions for the toy motion controller: state encoding, motor codes
// and the forward-run duration table indexed by speed level.
package controle_movimento_pkg;

  typedef enum logic [2:0] {
    DESLIGADO = 3'b000,
    PARADO    = 3'b001,
    FRENTE    = 3'b010,
    GIRO      = 3'b011,
    RE        = 3'b100
  } estado_t;

  localparam logic [1:0] MOTOR_PARA   = 2'b00;
  localparam logic [1:0] MOTOR_FRENTE = 2'b01;
  localparam logic [1:0] MOTOR_RE     = 2'b10;

  localparam logic [3:0] DUR_FRENTE_V1 = 4'd12;
  localparam logic [3:0] DUR_FRENTE_V2 = 4'd8;
  localparam logic [3:0] DUR_FRENTE_V3 = 4'd4;

  // Timer load value for a FRENTE entry; speed 0 never enters FRENTE.
  function automatic logic [3:0] carga_frente(input logic [1:0] vel);
    case (vel)
      2'd2:    return DUR_FRENTE_V2 - 4'd1;
      2'd3:    return DUR_FRENTE_V3 - 4'd1;
      default: return DUR_FRENTE_V1 - 4'd1;
    endcase
  endfunction

endpackage

// File: rtl/controle_movimento_timer.sv
// 4-bit loadable down-counter that times each action; load wins over a
// same-cycle decrement and the count stops at zero.
module temporizador_acao (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [3:0] load_value,
  input  logic       enable,
  output logic       zero
);

  logic [3:0] count_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_reg <= 4'd0;
    end else if (load) begin
      count_reg <= load_value;
    end else if (enable && (count_reg != 4'd0)) begin
      count_reg <= count_reg - 4'd1;
    end
  end

  assign zero = (count_reg == 4'd0);

endmodule

// File: rtl/controle_movimento.sv
// Motion controller FSM for a toy car: sequences stop/forward/turn/reverse on
// divider ticks, with a speed button and a BCD count of completed cycles.
module controle_movimento
  import controle_movimento_pkg::*;
#(
  parameter int T_PARADO = 2,
  parameter int T_GIRO   = 3,
  parameter int T_RE     = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       power,
  input  logic       tick,
  input  logic       pulso_velocidade,
  output logic [1:0] motor_esq,
  output logic [1:0] motor_dir,
  output logic [2:0] estado,
  output logic [1:0] velocidade,
  output logic [3:0] contagem_acao
);

  localparam logic [3:0] CARGA_PARADO = 4'(T_PARADO - 1);
  localparam logic [3:0] CARGA_GIRO   = 4'(T_GIRO - 1);
  localparam logic [3:0] CARGA_RE     = 4'(T_RE - 1);

  estado_t    state_reg, state_next;
  logic [1:0] vel_reg, vel_next, vel_inc;
  logic [3:0] bcd_reg, bcd_next;
  logic       t_load, t_enable, t_zero;
  logic [3:0] t_value;

  temporizador_acao u_timer (
    .clk        (clk),
    .reset      (reset),
    .load       (t_load),
    .load_value (t_value),
    .enable     (t_enable),
    .zero       (t_zero)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= DESLIGADO;
      vel_reg   <= 2'd1;
      bcd_reg   <= 4'd0;
    end else begin
      state_reg <= state_next;
      vel_reg   <= vel_next;
      bcd_reg   <= bcd_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    vel_next   = vel_reg;
    bcd_next   = bcd_reg;
    t_load     = 1'b0;
    t_value    = 4'd0;
    t_enable   = 1'b0;
    vel_inc    = pulso_velocidade ? vel_reg + 2'd1 : vel_reg;

    if (!power) begin
      state_next = DESLIGADO;
      vel_next   = 2'd1;
      bcd_next   = 4'd0;
      t_load     = 1'b1;
    end else if (state_reg == DESLIGADO) begin
      state_next = PARADO;
      t_load     = 1'b1;
      t_value    = CARGA_PARADO;
    end else begin
      vel_next = vel_inc;
      // Speed 0 freezes PARADO; a pulse that wraps to 0 parks at this very edge,
      // and any tick in the wrap cycle is discarded.
      if (vel_reg != 2'd0) begin
        if (vel_inc == 2'd0) begin
          state_next = PARADO;
          t_load     = 1'b1;
          t_value    = CARGA_PARADO;
        end else if (tick) begin
          if (!t_zero) begin
            t_enable = 1'b1;
          end else begin
            t_load = 1'b1;
            case (state_reg)
              PARADO: begin
                state_next = FRENTE;
                t_value    = carga_frente(vel_reg);
              end
              FRENTE: begin
                state_next = GIRO;
                t_value    = CARGA_GIRO;
              end
              GIRO: begin
                state_next = RE;
                t_value    = CARGA_RE;
              end
              RE: begin
                state_next = FRENTE;
                t_value    = carga_frente(vel_reg);
                bcd_next   = (bcd_reg == 4'd9) ? 4'd0 : bcd_reg + 4'd1;
              end
              default: state_next = DESLIGADO;
            endcase
          end
        end
      end
    end
  end

  always_comb begin
    motor_esq = MOTOR_PARA;
    motor_dir = MOTOR_PARA;
    case (state_reg)
      FRENTE: begin
        motor_esq = MOTOR_FRENTE;
        motor_dir = MOTOR_FRENTE;
      end
      GIRO: begin
        motor_esq = MOTOR_FRENTE;
        motor_dir = MOTOR_RE;
      end
      RE: begin
        motor_esq = MOTOR_RE;
        motor_dir = MOTOR_RE;
      end
      default: ;
    endcase
  end

  assign estado        = state_reg;
  assign velocidade    = vel_reg;
  assign contagem_acao = bcd_reg;

endmodule
